systolic_mm_ctrl: RTL
=====================

Name: systolic_mm_ctrl

Overview:
Sequencer for a DIM x DIM output-stationary array of tpumac PEs. One start pulse runs one matrix multiply:
- clears the PE accumulators;
- streams DIM operand vectors from the A/B buffers;
- waits for the skewed wavefront to finish;
- hands the DIM result rows to a consumer over a valid/ready handshake.

The block sits between the host command interface and the PE array plus its operand/result buffers. Operand skew (row/column i delayed by i cycles) is done by external skew registers, not by this block.

Parameters:
DIM, 8, array dimension (rows = columns = operand vector length), >= 2
CW, $clog2(3*DIM), width of the internal cycle counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle command pulse; accepted only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE state
mac_wr_en  output  1  to all PEs WrEn; loads Cin into accumulators
mac_en  output  1  to all PEs en; enables MAC/shift
cin_zero  output  1  forces array Cin inputs to 0 (with mac_wr_en)
ab_rd_en  output  1  read strobe to A and B operand buffers
ab_rd_addr  output  $clog2(DIM)  operand vector index (the k of A[:,k], B[k,:])
res_valid  output  1  result row available
res_ready  input  1  consumer accepts result row
res_row  output  $clog2(DIM)  index of row presented; selects array Cout row mux

Behaviour:
- Reset (async, rst_n low): state=IDLE, counter=0. All outputs 0: busy, done, mac_wr_en, mac_en, cin_zero, ab_rd_en, ab_rd_addr, res_valid, res_row. Reset asserted mid-operation aborts immediately; the accumulator contents are then don't-care.
- All outputs are registered, or decoded from registered state/counter only. No combinational path from res_ready or start to any output.
- IDLE: start=1 at an edge -> CLEAR. start in any other state is ignored and not queued.
- CLEAR (1 cycle): mac_wr_en=1, cin_zero=1, mac_en=0 -> COMPUTE, counter=0.
- COMPUTE (exactly 3*DIM-2 cycles, counter 0..3*DIM-3):
  - mac_en=1 throughout.
  - ab_rd_en=1 and ab_rd_addr=counter while counter<DIM; otherwise ab_rd_en=0, ab_rd_addr=0.
  - Length covers fill (DIM-1) + stream (DIM) + skew drain (DIM-1).
  - At counter=3*DIM-3 -> DRAIN, counter=0.
- DRAIN:
  - mac_en=0, res_valid=1, res_row=counter.
  - A row transfers when res_valid && res_ready at an edge; the counter then increments.
  - While res_ready=0, res_row holds and mac_en stays 0, so the array is frozen.
  - Transfer of row DIM-1 -> DONE.
- DONE (1 cycle): done=1, busy=1, everything else 0 -> IDLE.
- Counter never wraps. It is cleared on every state change and its maximum is 3*DIM-3 < 2^CW.
- Only one of mac_wr_en, mac_en, res_valid is ever high in a given cycle.

Decomposition:
- Shared package tpu_pkg holds:
  - state enum typedef (IDLE, CLEAR, COMPUTE, DRAIN, DONE);
  - function compute_cycles(dim) = 3*dim-2, reused by the array top and the bench.
- No sub-module. One FSM plus one counter in a single module.

Test Plan:
- DIM=4, out-of-reset reset check: all outputs 0 and busy=0 before first start; start at edge 0 -> CLEAR in cycle 1 (mac_wr_en=cin_zero=1).
- DIM=4, res_ready tied 1, start at edge 0 -> compute timing:
  - mac_en high cycles 2..11 (10 cycles);
  - ab_rd_en cycles 2..5 with addr 0,1,2,3;
  - res_valid cycles 12..15 with rows 0..3;
  - done cycle 16; busy low from cycle 17.
- Backpressure: res_ready=0 for 3 cycles while row 1 is presented -> res_row stays 1 and mac_en stays 0; done is delayed by exactly 3 cycles.
- start pulsed again during COMPUTE and during DONE -> ignored; exactly one done pulse, then IDLE.
- rst_n dropped mid-COMPUTE (counter=5), asynchronously between edges -> all outputs 0 immediately; the next start runs the full 10-cycle sequence.
- Integration check with a 4x4 tpumac array and the identity A times B = [[1..4],[5..8],[9..12],[13..16]] -> drained rows equal B. A leftover accumulator value of 3 is cleared by CLEAR and does not appear in the results.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic matrix-multiply datapath.
// Used by the sequencer, the array top and the bench.
package tpu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      COMPUTE,
      DRAIN,
      DONE
   } state_t;

   // Fill (dim-1) + stream (dim) + skew drain (dim-1).
   function automatic int compute_cycles(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage

// File: rtl/systolic_mm_ctrl.sv
// Sequencer for a DIM x DIM output-stationary tpumac array:
// clear, stream operands, wait for the wavefront, drain result rows.
module systolic_mm_ctrl
   import tpu_pkg::*;
#(
   parameter int DIM = 8,
   parameter int CW  = $clog2(3 * DIM)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   mac_wr_en,
   output logic                   mac_en,
   output logic                   cin_zero,
   output logic                   ab_rd_en,
   output logic [$clog2(DIM)-1:0] ab_rd_addr,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [$clog2(DIM)-1:0] res_row
);

   localparam int AW = $clog2(DIM);
   localparam logic [CW-1:0] LAST_C = CW'(compute_cycles(DIM) - 1);
   localparam logic [CW-1:0] LAST_R = CW'(DIM - 1);
   localparam logic [CW-1:0] N_RD   = CW'(DIM);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Counter restarts at zero on every state change.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (start) state_n = CLEAR;
         end
         CLEAR: begin
            state_n = COMPUTE;
            cnt_n   = '0;
         end
         COMPUTE: begin
            if (cnt == LAST_C) begin
               state_n = DRAIN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         DRAIN: begin
            if (res_ready) begin
               if (cnt == LAST_R) begin
                  state_n = DONE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      mac_wr_en  = 1'b0;
      mac_en     = 1'b0;
      cin_zero   = 1'b0;
      ab_rd_en   = 1'b0;
      ab_rd_addr = '0;
      res_valid  = 1'b0;
      res_row    = '0;
      case (state)
         CLEAR: begin
            busy      = 1'b1;
            mac_wr_en = 1'b1;
            cin_zero  = 1'b1;
         end
         COMPUTE: begin
            busy   = 1'b1;
            mac_en = 1'b1;
            if (cnt < N_RD) begin
               ab_rd_en   = 1'b1;
               ab_rd_addr = cnt[AW-1:0];
            end
         end
         DRAIN: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            res_row   = cnt[AW-1:0];
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

endmodule
